// File: rtl/instr_dispatch_pkg.sv
// Shared instruction formats, type codes and buffer entry layout for the dispatch stage.
// Combinational helpers only; no latency and no flow control live here.
package instr_dispatch_pkg;

    typedef enum logic [1:0] {
        INSTR_TYPE_ARITHMETIC = 2'b00,
        INSTR_TYPE_RAM        = 2'b01,
        INSTR_TYPE_LD_ST      = 2'b10,
        INSTR_TYPE_ILLEGAL    = 2'b11
    } instr_type_e;

    localparam int DISPATCH_DEPTH = 2;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [9:0]  relu;
        logic [15:0] src_addr;
        logic [15:0] dst_addr;
        logic [15:0] len;
    } math_instr_t;

    typedef struct packed {
        logic [31:0] ext_addr;
        logic [15:0] loc_addr;
        logic [15:0] len;
    } dma_instruction_t;

    typedef struct packed {
        logic        wr;
        logic [6:0]  reg_addr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [7:0]  tag;
    } regfile_instruction_t;

    // All three formats are 64 bits so one union slot carries any of them.
    typedef union packed {
        math_instr_t          math;
        dma_instruction_t     dma;
        regfile_instruction_t cache;
    } instr_payload_u;

    typedef struct packed {
        logic [1:0]     typ;
        instr_payload_u pl;
    } dispatch_entry_t;

    function automatic dispatch_entry_t pack_entry(
        input logic [1:0]           typ,
        input math_instr_t          m,
        input dma_instruction_t     d,
        input regfile_instruction_t c
    );
        dispatch_entry_t e;
        e.typ = typ;
        e.pl  = '0;
        case (typ)
            INSTR_TYPE_ARITHMETIC: e.pl.math  = m;
            INSTR_TYPE_RAM:        e.pl.dma   = d;
            INSTR_TYPE_LD_ST:      e.pl.cache = c;
            default:               e.pl       = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dispatch_skid_buf.sv
// Two-entry in-order buffer of dispatch entries; push visible at head the next cycle.
// No internal backpressure: the parent never pushes when full or pops when empty.
module dispatch_skid_buf
    import instr_dispatch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  dispatch_entry_t push_dat,
    input  logic            pop,
    output dispatch_entry_t head_dat,
    output logic            head_vld,
    output logic [1:0]      occupancy
);

    dispatch_entry_t mem_q [DISPATCH_DEPTH];
    dispatch_entry_t mem_d [DISPATCH_DEPTH];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DISPATCH_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat  = mem_q[rd_ptr_q];
    assign head_vld  = (cnt_q != 2'd0);
    assign occupancy = cnt_q;

    a_no_overflow:  assert property (@(posedge clk) disable iff (reset)
                                     !(push && !pop && cnt_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
                                     !(pop && cnt_q == 2'd0));

endmodule

// File: rtl/instr_dispatch.sv
// Routes queued instructions in order to math/DMA/cache units with a DMA->cache fence.
// iq_re to unit valid is 2 cycles; stalls hold the head stable and throttle iq_re.
module instr_dispatch
    import instr_dispatch_pkg::*;
#(
    parameter int MAX_DMA_OUTSTANDING = 4,
    parameter int CNT_W               = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 iq_re,
    input  logic                 iq_empty,
    input  logic [1:0]           iq_instr_type,
    input  math_instr_t          iq_math_instr,
    input  dma_instruction_t     iq_dma_instr,
    input  regfile_instruction_t iq_cache_instr,
    output logic                 math_valid,
    input  logic                 math_ready,
    output math_instr_t          math_instr,
    output logic                 dma_valid,
    input  logic                 dma_ready,
    output dma_instruction_t     dma_instr,
    output logic                 cache_valid,
    input  logic                 cache_ready,
    output regfile_instruction_t cache_instr,
    input  logic                 dma_done,
    output logic [CNT_W-1:0]     dma_outstanding,
    output logic                 illegal_instr,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DMA_OUTSTANDING);

    logic             rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0] dma_cnt_q, dma_cnt_d;

    dispatch_entry_t  cap_dat;
    dispatch_entry_t  head_dat;
    logic             head_vld;
    logic [1:0]       occupancy;

    logic is_arith, is_ram, is_ldst, is_ill;
    logic dma_room, done_eff;
    logic math_fire, dma_fire, cache_fire, pop;
    logic [2:0] inflight;

    assign cap_dat = pack_entry(iq_instr_type, iq_math_instr, iq_dma_instr, iq_cache_instr);

    dispatch_skid_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pend_q),
        .push_dat  (cap_dat),
        .pop       (pop),
        .head_dat  (head_dat),
        .head_vld  (head_vld),
        .occupancy (occupancy)
    );

    always_comb begin
        is_arith = head_vld && (head_dat.typ == INSTR_TYPE_ARITHMETIC);
        is_ram   = head_vld && (head_dat.typ == INSTR_TYPE_RAM);
        is_ldst  = head_vld && (head_dat.typ == INSTR_TYPE_LD_ST);
        is_ill   = head_vld && (head_dat.typ == INSTR_TYPE_ILLEGAL);

        done_eff = dma_done && (dma_cnt_q != '0);
        // A completion in this cycle frees a slot for the waiting DMA head immediately.
        dma_room = (dma_cnt_q < MAX_C) || done_eff;

        math_valid    = is_arith;
        dma_valid     = is_ram && dma_room;
        cache_valid   = is_ldst && (dma_cnt_q == '0);
        illegal_instr = is_ill;

        math_fire  = math_valid && math_ready;
        dma_fire   = dma_valid && dma_ready;
        cache_fire = cache_valid && cache_ready;
        pop        = math_fire || dma_fire || cache_fire || is_ill;

        inflight = {1'b0, occupancy} + {2'b00, rd_pend_q} - {2'b00, pop};
        iq_re    = !reset && !iq_empty && (inflight < 3'd2);

        rd_pend_d = iq_re;

        dma_cnt_d = dma_cnt_q;
        if (dma_fire && !done_eff) begin
            dma_cnt_d = dma_cnt_q + CNT_W'(1);
        end else if (!dma_fire && done_eff) begin
            dma_cnt_d = dma_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            dma_cnt_q <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            dma_cnt_q <= dma_cnt_d;
        end
    end

    assign math_instr      = head_dat.pl.math;
    assign dma_instr       = head_dat.pl.dma;
    assign cache_instr     = head_dat.pl.cache;
    assign dma_outstanding = dma_cnt_q;
    assign busy            = head_vld || rd_pend_q || (dma_cnt_q != '0);

    a_done_underflow: assert property (@(posedge clk) disable iff (reset)
                                       !(dma_done && dma_cnt_q == '0));
    a_no_empty_read:  assert property (@(posedge clk) disable iff (reset)
                                       !(iq_re && iq_empty));

endmodule
